afisaj_7seg: RTL and testbench

Time-multiplexed driver for a 4-digit common-anode 7-segment display, placed directly downstream of the binary-to-BCD converter; it consumes the `mii`/`sute`/`zeci`/`unitati` digit outputs. It latches a new 4-digit value on a `valid` strobe and switches the display over only at a frame boundary, so a frame never shows a mix of old and new digits. It scans one digit at a time, with optional leading-zero blanking and a dash glyph for non-decimal digit codes.

---
 rtl/bcd_pkg.sv | 32 +++
 rtl/decodor_7seg.sv | 27 ++
 rtl/afisaj_7seg.sv | 136 +++++++++++++
 tb/tb_afisaj_7seg.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants for BCD 7-segment display users: active-high gfedcba glyphs,
// the all-off active-low segment pattern and scan slot indices.
package bcd_pkg;

  localparam logic [6:0] GLYPH_0    = 7'b0111111;
  localparam logic [6:0] GLYPH_1    = 7'b0000110;
  localparam logic [6:0] GLYPH_2    = 7'b1011011;
  localparam logic [6:0] GLYPH_3    = 7'b1001111;
  localparam logic [6:0] GLYPH_4    = 7'b1100110;
  localparam logic [6:0] GLYPH_5    = 7'b1101101;
  localparam logic [6:0] GLYPH_6    = 7'b1111101;
  localparam logic [6:0] GLYPH_7    = 7'b0000111;
  localparam logic [6:0] GLYPH_8    = 7'b1111111;
  localparam logic [6:0] GLYPH_9    = 7'b1101111;
  localparam logic [6:0] GLYPH_DASH = 7'b1000000;

  localparam logic [6:0] SEG_OFF    = 7'b1111111;
  localparam logic [3:0] AN_OFF     = 4'b1111;

  localparam logic [1:0] SLOT_UNITATI = 2'd0;
  localparam logic [1:0] SLOT_ZECI    = 2'd1;
  localparam logic [1:0] SLOT_SUTE    = 2'd2;
  localparam logic [1:0] SLOT_MII     = 2'd3;

  // Active-low anode pattern lighting exactly one slot.
  function automatic logic [3:0] anode_sel(input logic [1:0] slot);
    logic [3:0] r_oh;
    r_oh = 4'b0001 << slot;
    return ~r_oh;
  endfunction

endpackage

// File: rtl/decodor_7seg.sv
// Combinational 4-bit code to active-high gfedcba glyph; codes 10..15 map to a dash.
// Zero latency, no flow control.
module decodor_7seg
  import bcd_pkg::*;
(
  input  logic [3:0] i_cod,
  output logic [6:0] o_glyph
);

  always_comb begin
    o_glyph = GLYPH_DASH;
    case (i_cod)
      4'd0:    o_glyph = GLYPH_0;
      4'd1:    o_glyph = GLYPH_1;
      4'd2:    o_glyph = GLYPH_2;
      4'd3:    o_glyph = GLYPH_3;
      4'd4:    o_glyph = GLYPH_4;
      4'd5:    o_glyph = GLYPH_5;
      4'd6:    o_glyph = GLYPH_6;
      4'd7:    o_glyph = GLYPH_7;
      4'd8:    o_glyph = GLYPH_8;
      4'd9:    o_glyph = GLYPH_9;
      default: o_glyph = GLYPH_DASH;
    endcase
  end

endmodule

// File: rtl/afisaj_7seg.sv
// Time-multiplexed 4-digit common-anode 7-segment driver; new values are swapped
// in only at a frame boundary so a frame never mixes old and new digits.
module afisaj_7seg
  import bcd_pkg::*;
#(
  parameter int CLK_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [3:0] mii,
  input  logic [3:0] sute,
  input  logic [3:0] zeci,
  input  logic [3:0] unitati,
  input  logic       blank_en,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       aplicat
);

  localparam int               PRE_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);

  logic [PRE_W-1:0] r_pre;
  logic [1:0]       r_idx;
  logic [15:0]      r_pend;
  logic             r_pend_v;
  logic [15:0]      r_disp;
  logic [6:0]       r_seg;
  logic [3:0]       r_an;
  logic             r_aplicat;

  logic [PRE_W-1:0] w_pre_nxt;
  logic [1:0]       w_idx_nxt;
  logic [15:0]      w_pend_nxt;
  logic             w_pend_v_nxt;
  logic [15:0]      w_disp_nxt;
  logic             w_tick;
  logic             w_frame;
  logic             w_load;
  logic [15:0]      w_in;
  logic [3:0]       w_digit;
  logic             w_blank;
  logic [6:0]       w_glyph;
  logic [6:0]       w_seg;
  logic [3:0]       w_an;

  assign w_in    = {mii, sute, zeci, unitati};
  assign w_tick  = (r_pre == PRE_MAX);
  assign w_frame = w_tick && (r_idx == SLOT_MII);

  always_comb begin
    w_pre_nxt = w_tick ? '0 : r_pre + PRE_W'(1);
    w_idx_nxt = w_tick ? r_idx + 2'd1 : r_idx;
  end

  // A strobe landing on the boundary itself bypasses the pending register.
  always_comb begin
    w_disp_nxt   = r_disp;
    w_pend_nxt   = r_pend;
    w_pend_v_nxt = r_pend_v;
    w_load       = 1'b0;
    if (w_frame) begin
      if (valid) begin
        w_disp_nxt = w_in;
        w_load     = 1'b1;
      end else if (r_pend_v) begin
        w_disp_nxt = r_pend;
        w_load     = 1'b1;
      end
      w_pend_v_nxt = 1'b0;
    end else if (valid) begin
      w_pend_nxt   = w_in;
      w_pend_v_nxt = 1'b1;
    end
  end

  // Outputs are computed from next-state so slot 0 of a new value lands
  // in the same cycle as the aplicat pulse.
  always_comb begin
    w_digit = w_disp_nxt[3:0];
    w_blank = 1'b0;
    case (w_idx_nxt)
      SLOT_UNITATI: w_digit = w_disp_nxt[3:0];
      SLOT_ZECI: begin
        w_digit = w_disp_nxt[7:4];
        w_blank = blank_en && (w_disp_nxt[15:4] == 12'd0);
      end
      SLOT_SUTE: begin
        w_digit = w_disp_nxt[11:8];
        w_blank = blank_en && (w_disp_nxt[15:8] == 8'd0);
      end
      default: begin
        w_digit = w_disp_nxt[15:12];
        w_blank = blank_en && (w_disp_nxt[15:12] == 4'd0);
      end
    endcase
  end

  decodor_7seg u_dec (
    .i_cod   (w_digit),
    .o_glyph (w_glyph)
  );

  always_comb begin
    w_seg = w_blank ? SEG_OFF : ~w_glyph;
    w_an  = w_blank ? AN_OFF  : anode_sel(w_idx_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre     <= '0;
      r_idx     <= SLOT_UNITATI;
      r_pend    <= 16'd0;
      r_pend_v  <= 1'b0;
      r_disp    <= 16'd0;
      r_seg     <= SEG_OFF;
      r_an      <= AN_OFF;
      r_aplicat <= 1'b0;
    end else begin
      r_pre     <= w_pre_nxt;
      r_idx     <= w_idx_nxt;
      r_pend    <= w_pend_nxt;
      r_pend_v  <= w_pend_v_nxt;
      r_disp    <= w_disp_nxt;
      r_seg     <= w_seg;
      r_an      <= w_an;
      r_aplicat <= w_load;
    end
  end

  assign seg     = r_seg;
  assign an      = r_an;
  assign aplicat = r_aplicat;

endmodule

// File: tb/tb_afisaj_7seg.sv
// Directed plus randomized bench for afisaj_7seg at CLK_DIV=4, checked against a
// cycle-count based model of which slot is lit and which value is visible.
module tb_afisaj_7seg;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic       clk;
  logic       rst;
  logic       valid;
  logic [3:0] mii, sute, zeci, unitati;
  logic       blank_en;
  logic [6:0] seg;
  logic [3:0] an;
  logic       aplicat;

  int checks;
  int failures;

  // Model: n = cycles since reset release; the visible value and pending value.
  int          n;
  logic [15:0] m_vis;
  logic [15:0] m_pend;
  bit          m_pv;
  bit          exp_ap;
  logic [6:0]  seg_tbl [16];

  afisaj_7seg #(.CLK_DIV(DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .valid    (valid),
    .mii      (mii),
    .sute     (sute),
    .zeci     (zeci),
    .unitati  (unitati),
    .blank_en (blank_en),
    .seg      (seg),
    .an       (an),
    .aplicat  (aplicat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s n=%0d got=%h exp=%h", tag, n, got, exp);
    end
  endtask

  function automatic logic [15:0] rnd_val();
    logic [15:0] v;
    v = 16'd0;
    for (int k = 0; k < 4; k++) begin
      if ($urandom_range(0, 2) != 0) v[4*k +: 4] = 4'($urandom_range(0, 15));
    end
    return v;
  endfunction

  task automatic step(input bit v, input logic [15:0] val, input bit be);
    int          s;
    logic [15:0] hi;
    bit          blk;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    valid = v;
    {mii, sute, zeci, unitati} = val;
    blank_en = be;
    @(posedge clk);
    exp_ap = 1'b0;
    if (n % FRAME == FRAME - 1) begin
      if (v) begin
        m_vis  = val;
        exp_ap = 1'b1;
      end else if (m_pv) begin
        m_vis  = m_pend;
        exp_ap = 1'b1;
      end
      m_pv = 1'b0;
    end else if (v) begin
      m_pend = val;
      m_pv   = 1'b1;
    end
    n++;
    #1;
    valid = 1'b0;
    s     = (n / DIV) % 4;
    hi    = m_vis >> (4 * s);
    blk   = be && (s > 0) && (hi == 16'd0);
    e_seg = blk ? 7'h7F : seg_tbl[hi[3:0]];
    e_an  = blk ? 4'hF : ~(4'b0001 << s);
    chk("an", {12'd0, an}, {12'd0, e_an});
    chk("seg", {9'd0, seg}, {9'd0, e_seg});
    chk("aplicat", {15'd0, aplicat}, {15'd0, exp_ap});
  endtask

  task automatic goto_phase(input int p, input bit be);
    while (n % FRAME != p) step(1'b0, rnd_val(), be);
  endtask

  task automatic do_reset(input int k);
    rst   = 1'b1;
    valid = 1'b0;
    repeat (k) begin
      @(posedge clk);
      #1;
      chk("rst_an", {12'd0, an}, 16'h000F);
      chk("rst_seg", {9'd0, seg}, 16'h007F);
      chk("rst_aplicat", {15'd0, aplicat}, 16'h0000);
    end
    rst    = 1'b0;
    n      = 0;
    m_vis  = 16'd0;
    m_pend = 16'd0;
    m_pv   = 1'b0;
    exp_ap = 1'b0;
  endtask

  initial begin
    seg_tbl[0] = 7'b1000000;  seg_tbl[1] = 7'b1111001;
    seg_tbl[2] = 7'b0100100;  seg_tbl[3] = 7'b0110000;
    seg_tbl[4] = 7'b0011001;  seg_tbl[5] = 7'b0010010;
    seg_tbl[6] = 7'b0000010;  seg_tbl[7] = 7'b1111000;
    seg_tbl[8] = 7'b0000000;  seg_tbl[9] = 7'b0010000;
    for (int k = 10; k < 16; k++) seg_tbl[k] = 7'b0111111;
    checks = 0; failures = 0; n = 0;
    m_vis = 16'd0; m_pend = 16'd0; m_pv = 1'b0; exp_ap = 1'b0;
    rst = 1'b1; valid = 1'b0; blank_en = 1'b0;
    {mii, sute, zeci, unitati} = 16'd0;

    do_reset(2);
    repeat (6) step(1'b0, rnd_val(), 1'b0);
    step(1'b1, 16'h9999, 1'b0);
    do_reset(3);

    // Scan order with 1234
    repeat (5) step(1'b0, rnd_val(), 1'b0);
    step(1'b1, 16'h1234, 1'b0);
    repeat (40) step(1'b0, rnd_val(), 1'b0);

    // Frame sync: single strobe, double strobe, strobe on the boundary
    goto_phase(5, 1'b0);
    step(1'b1, 16'h0007, 1'b0);
    repeat (24) step(1'b0, rnd_val(), 1'b0);
    goto_phase(6, 1'b0);
    step(1'b1, 16'h0007, 1'b0);
    goto_phase(11, 1'b0);
    step(1'b1, 16'h0008, 1'b0);
    repeat (24) step(1'b0, rnd_val(), 1'b0);
    goto_phase(FRAME - 1, 1'b0);
    step(1'b1, 16'h4321, 1'b0);
    repeat (20) step(1'b0, rnd_val(), 1'b0);

    // Leading-zero blanking
    goto_phase(3, 1'b1);
    step(1'b1, 16'h0042, 1'b1);
    repeat (36) step(1'b0, rnd_val(), 1'b1);
    step(1'b1, 16'h0000, 1'b1);
    repeat (36) step(1'b0, rnd_val(), 1'b1);
    step(1'b1, 16'h0500, 1'b1);
    repeat (36) step(1'b0, rnd_val(), 1'b1);

    // Non-decimal code in the tens slot
    step(1'b1, 16'h12C4, 1'b0);
    repeat (36) step(1'b0, rnd_val(), 1'b0);

    // Randomized traffic
    repeat (400) step($urandom_range(0, 7) == 0, rnd_val(), 1'($urandom_range(0, 1)));

    // Reset mid-frame with a pending value outstanding
    goto_phase(9, 1'b0);
    step(1'b1, 16'hABCD, 1'b0);
    do_reset(3);
    repeat (40) step(1'b0, rnd_val(), 1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
